// File: rtl/alu_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO register and stalls the pipeline while running.
module alu_div (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [31:0]   dividend_i,
    input  logic [31:0]   divisor_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          ready_o,
    output logic [63:0]   result_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [W-1:0]      quo_q, quo_d;
    logic [W-1:0]      dvs_q, dvs_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic [2*W-1:0]    result_q, result_d;

    logic [W-1:0]      abs_dvd, abs_dvs;
    logic [W:0]        rem_sh, diff;
    logic [W-1:0]      step_rem, step_quo;
    logic [W-1:0]      fin_rem, fin_quo;

    // Operand magnitudes; signs only matter for DIV.
    assign abs_dvd = (signed_i && dividend_i[W-1]) ? (W'(0) - dividend_i) : dividend_i;
    assign abs_dvs = (signed_i && divisor_i[W-1])  ? (W'(0) - divisor_i)  : divisor_i;

    // One restoring step: shift, 33-bit trial subtract, keep on no borrow.
    assign rem_sh   = {rem_q, quo_q[W-1]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign step_rem = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
    assign step_quo = {quo_q[W-2:0], ~diff[W]};

    // Sign correction happens only on the final step.
    assign fin_quo  = qsign_q ? (W'(0) - step_quo) : step_quo;
    assign fin_rem  = rsign_q ? (W'(0) - step_rem) : step_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rem_d   = '0;
                        quo_d   = abs_dvd;
                        dvs_d   = abs_dvs;
                        qsign_d = signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
                        rsign_d = signed_i & dividend_i[W-1];
                        cnt_d   = '0;
                        if (divisor_i == '0) begin
                            result_d = {dividend_i, {W{1'b1}}};
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        result_d = {fin_rem, fin_quo};
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Accepting cycle already stalls; DONE lets the instruction advance.
    assign busy_o   = !flush_i && ((state_q == S_BUSY) || ((state_q == S_IDLE) && start_i));
    assign ready_o  = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_div.sv
// Scoreboard bench for alu_div: expected results are queued at issue and compared at ready_o.
module tb_alu_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [63:0] result_o;

    int          n_checks;
    int          n_pass;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;

    alu_div dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    // Reference model using wide host arithmetic.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Enter a new cycle and present a request; the caller observes cycle 0.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        @(posedge clk); #1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        if (push) sb_q.push_back(exp);
    endtask

    // Advance cycles until ready_o; lat is the cycle number or -1 on timeout.
    task automatic wait_ready(input int max, input bit hold, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            @(posedge clk); #1;
            if (hold) dividend_i = $urandom;
            else      start_i = 1'b0;
            @(negedge clk);
            if (ready_o) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy_o); else n_pass++;
        n_checks++;
        if (ready_o !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready_o); else n_pass++;
        n_checks++;
        if (result_o !== 64'h0) $display("FAIL reset_result got=%h want=0", result_o); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_divu_basic;
        int bad_busy, bad_ready;
        logic [63:0] exp;
        bad_busy  = 0;
        bad_ready = 0;
        issue(1'b0, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E);
        @(negedge clk);
        if (busy_o !== 1'b1) bad_busy++;
        if (ready_o !== 1'b0) bad_ready++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (busy_o !== (c <= 32)) bad_busy++;
            if (ready_o !== (c == 33)) bad_ready++;
            if (c == 33) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (result_o !== exp) $display("FAIL divu_100_7 got=%h want=%h", result_o, exp);
                else n_pass++;
                last_exp = exp;
            end
        end
        n_checks++;
        if (bad_busy != 0) $display("FAIL divu_busy_profile bad_cycles=%0d want=0", bad_busy); else n_pass++;
        n_checks++;
        if (bad_ready != 0) $display("FAIL divu_ready_profile bad_cycles=%0d want=0", bad_ready); else n_pass++;
    endtask

    task automatic test_signed;
        int lat;
        logic [63:0] exp;
        // start_i stays high with changing operands through BUSY and DONE
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        wait_ready(40, 1'b1, lat);
        n_checks++;
        if (lat != 33) $display("FAIL div_neg7_2_latency got=%0d want=33", lat); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL div_neg7_2 got=%h want=%h", result_o, exp); else n_pass++;
        last_exp = exp;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_o, ready_o} !== 2'b00) $display("FAIL done_ignores_start got=%b want=00", {busy_o, ready_o});
        else n_pass++;

        issue(1'b0, 32'hFFFFFFF9, 32'd2, 1'b1, 64'h00000001_7FFFFFFC);
        wait_ready(40, 1'b0, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL divu_fff9_2 got=%h want=%h lat=%0d", result_o, exp, lat); else n_pass++;

        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000);
        wait_ready(40, 1'b0, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL div_min_neg1 got=%h want=%h lat=%0d", result_o, exp, lat); else n_pass++;

        issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 64'h00000000_FFFFFFFF);
        wait_ready(40, 1'b0, lat);
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL divu_max_1 got=%h want=%h lat=%0d", result_o, exp, lat); else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_zero_div;
        int lat;
        logic [63:0] exp;
        issue(1'b0, 32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF);
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL zero_busy_c0 got=%b want=1", busy_o); else n_pass++;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_o, ready_o} !== 2'b01) $display("FAIL zero_c1_busy_ready got=%b want=01", {busy_o, ready_o});
        else n_pass++;
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL divu_5_0 got=%h want=%h", result_o, exp); else n_pass++;

        // earliest follow-on accept is cycle 2
        issue(1'b1, 32'h80000000, 32'd0, 1'b1, model(1'b1, 32'h80000000, 32'd0));
        wait_ready(5, 1'b0, lat);
        n_checks++;
        if (lat != 1) $display("FAIL zero_b2b_latency got=%0d want=1", lat); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL div_min_0 got=%h want=%h", result_o, exp); else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_flush;
        int lat;
        logic [63:0] exp;
        issue(1'b0, 32'd1000, 32'd10, 1'b0, 64'h0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (c == 10) flush_i = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL flush_busy_c10 got=%b want=0", busy_o); else n_pass++;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_o, ready_o} !== 2'b00) $display("FAIL flush_idle_c11 got=%b want=00", {busy_o, ready_o});
        else n_pass++;
        n_checks++;
        if (result_o !== last_exp) $display("FAIL flush_result_held got=%h want=%h", result_o, last_exp);
        else n_pass++;

        issue(1'b0, 32'd9, 32'd3, 1'b1, 64'h00000000_00000003);
        wait_ready(40, 1'b0, lat);
        n_checks++;
        if (lat != 33) $display("FAIL after_flush_latency got=%0d want=33", lat); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL divu_9_3 got=%h want=%h", result_o, exp); else n_pass++;
        last_exp = exp;

        // flush wins over start in IDLE
        issue(1'b0, 32'd4, 32'd2, 1'b0, 64'h0);
        flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL flush_prio_busy got=%b want=0", busy_o); else n_pass++;
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_o, ready_o} !== 2'b00) $display("FAIL flush_prio_not_accepted got=%b want=00", {busy_o, ready_o});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [63:0] exp;
        logic [31:0] a, b;
        logic s;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'(($urandom & 32'hFF) | 32'h80000000) : 32'(($urandom >> (4 * i)) | 32'd1);
            s = 1'(i & 1);
            issue(s, a, b, 1'b1, model(s, a, b));
            wait_ready(40, 1'b0, lat);
            n_checks++;
            if (lat != 33) $display("FAIL b2b_latency_%0d got=%0d want=33", i, lat); else n_pass++;
            exp = sb_q.pop_front();
            n_checks++;
            if (result_o !== exp) $display("FAIL b2b_result_%0d s=%b a=%h b=%h got=%h want=%h", i, s, a, b, result_o, exp);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        int lat;
        logic [63:0] exp;
        issue(1'b0, 32'd100, 32'd3, 1'b0, 64'h0);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, ready_o} !== 2'b00) $display("FAIL async_rst_busy_ready got=%b want=00", {busy_o, ready_o});
        else n_pass++;
        n_checks++;
        if (result_o !== 64'h0) $display("FAIL async_rst_result got=%h want=0", result_o); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1'b0, 32'd7, 32'd7, 1'b1, 64'h00000000_00000001);
        wait_ready(40, 1'b0, lat);
        n_checks++;
        if (lat != 33) $display("FAIL post_rst_latency got=%0d want=33", lat); else n_pass++;
        exp = sb_q.pop_front();
        n_checks++;
        if (result_o !== exp) $display("FAIL divu_7_7 got=%h want=%h", result_o, exp); else n_pass++;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        flush_i    = 1'b0;
        n_checks   = 0;
        n_pass     = 0;
        last_exp   = '0;

        test_reset;
        test_divu_basic;
        test_signed;
        test_zero_div;
        test_flush;
        test_back_to_back;
        test_async_reset;

        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drained left=%0d want=0", sb_q.size()); else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_div.md
# alu_div

Multi-cycle radix-2 restoring divider for the EX stage, executing DIV and DIVU. It produces the 64-bit {HI, LO} = {remainder, quotient} pair written into the HI/LO register. That register is what MFHI/MFLO later read through the EX move path. While a division is in flight the block holds the pipeline through `busy_o`, and it supports cancellation by pipeline flush.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  EX stage holds a DIV/DIVU; request a division.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i`.
- `dividend_i`  in  32  rs operand; sampled on the accepting edge.
- `divisor_i`  in  32  rt operand; sampled on the accepting edge.
- `flush_i`  in  1  exception/flush; cancels any operation.
- `busy_o`  out  1  stall request to pipeline control.
- `ready_o`  out  1  result valid this cycle (one-cycle pulse).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; registered.

## Operation
- States: IDLE, BUSY, DONE.
- Accept: the request is accepted in IDLE with `start_i`=1 and `flush_i`=0. On that edge the block:
  - latches |dividend|, |divisor|, the quotient sign (dividend[31]^divisor[31]) and the remainder sign (dividend[31]);
  - uses signs only when `signed_i`=1, treating operands as unsigned otherwise;
  - clears the step counter (5 bits).
- Normal path: accept → BUSY.
- Zero divisor: `divisor_i`==0 at accept → DONE directly, loading `result_o` = {dividend_i, 32'hFFFFFFFF}. The same value applies in signed and unsigned mode.
- BUSY, one step per edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude with a 33-bit subtractor.
  - On no borrow, keep the difference and set quotient LSB = 1.
  - Increment the counter.
  - On the step with counter==31, load `result_o` with the sign-corrected values and go to DONE.
- Sign correction:
  - Quotient is negated when the quotient sign is 1.
  - Remainder is negated when the remainder sign is 1.
  - Magnitudes are handled as 32-bit unsigned, so 0x80000000 is representable.
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no trap.
- DONE: `ready_o`=1 for exactly one cycle, then IDLE. `start_i` is ignored in DONE.
- `start_i` is ignored in BUSY; operands are not re-sampled.
- Flush:
  - `flush_i`=1 in any state → IDLE on the next edge.
  - No `ready_o` is produced and `result_o` is not updated.
  - A flush in DONE suppresses nothing already visible, because `ready_o` for that cycle has already been presented.
  - `flush_i` has priority over `start_i` in IDLE.
- `result_o` holds its last value until the next completion or reset.

## Timing
- Reset (async, any state): state=IDLE, counter=0, internal registers=0, `result_o`=64'h0, `ready_o`=0, `busy_o`=0.
- `busy_o` is combinational:
  - 1 in IDLE when `start_i`=1 and `flush_i`=0 and `divisor_i`≠0, so the accepting cycle already stalls;
  - 1 in IDLE when `start_i`=1 and `flush_i`=0 with a zero divisor;
  - 1 throughout BUSY;
  - 0 in DONE, where the instruction advances and captures `result_o`;
  - 0 while `flush_i`=1.
- `ready_o` is a registered state decode, equal to state==DONE.
- Latency, with the accept cycle numbered 0:
  - normal division: BUSY in cycles 1–32, `ready_o`=1 in cycle 33;
  - zero divisor: `ready_o`=1 in cycle 1.
- Back-to-back: a new `start_i` is accepted in cycle 34 at the earliest, or cycle 2 for a zero divisor.
- Critical path: one 33-bit subtract plus mux per cycle. Negation is done once, at completion.

## Test plan
- DIVU 100 / 7, start in cycle 0 → `busy_o` high in cycles 0–32; `ready_o` pulse in cycle 33 only; `result_o`=64'h00000002_0000000E.
- DIV 0xFFFFFFF9 (−7) / 2 → `result_o`=64'hFFFFFFFF_FFFFFFFD (rem −1, quot −3). The same operands with DIVU → 64'h00000001_7FFFFFFC.
- DIV 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000. DIVU 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
- DIVU 5 / 0 → `ready_o` in cycle 1; `result_o`=64'h00000005_FFFFFFFF; `busy_o` high in cycle 0 only.
- Start 1000/10, assert `flush_i` in cycle 10:
  - IDLE in cycle 11, no `ready_o`, `result_o` unchanged;
  - start 9/3 in cycle 12 → `ready_o` in cycle 45, `result_o`=64'h0_00000003.
- Assert `rst` asynchronously mid-BUSY (cycle 20) → all outputs 0 immediately. After release, a fresh DIVU 7/7 gives 64'h0_00000001 after 33 cycles.
